// File: rtl/register_file_1r_1w_bist_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_bist_pkg
// Description : Types and March C- element tables for the register-file BIST
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_bist_pkg;

    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } march_elem_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } bist_state_e;

    // Element tables, bit index = element number (E5..E0 from left to right).
    // Direction: 1 = ascending addresses, 0 = descending.
    localparam logic [5:0] C_ELEM_UP  = 6'b100111;
    // Two operations (read then write) per address; otherwise one.
    localparam logic [5:0] C_ELEM_TWO = 6'b011110;
    // Background expected on the read of each element.
    localparam logic [5:0] C_ELEM_RD  = 6'b010100;
    // Background written by each element.
    localparam logic [5:0] C_ELEM_WR  = 6'b001010;

    function automatic logic elem_up(input march_elem_e e);
        return C_ELEM_UP[e];
    endfunction

    function automatic logic elem_two(input march_elem_e e);
        return C_ELEM_TWO[e];
    endfunction

    function automatic logic elem_rd_bg(input march_elem_e e);
        return C_ELEM_RD[e];
    endfunction

    function automatic logic elem_wr_bg(input march_elem_e e);
        return C_ELEM_WR[e];
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_1r_1w_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_1r_1w_bist_ctrl_if
// Description : Control/status and wrapper test-port bundle of the BIST
//               sequencer. master = sequencer, slave = SoC controller/wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_1r_1w_bist_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  bist_start;
    logic                  bist_busy;
    logic                  bist_done;
    logic                  bist_fail;
    logic [ADDR_WIDTH-1:0] fail_addr;
    logic                  BIST;
    logic                  CSN_T;
    logic                  WEN_T;
    logic [ADDR_WIDTH-1:0] A_T;
    logic [DATA_WIDTH-1:0] D_T;
    logic [DATA_WIDTH-1:0] Q_T;

    modport master (
        input  bist_start, Q_T,
        output bist_busy, bist_done, bist_fail, fail_addr,
        output BIST, CSN_T, WEN_T, A_T, D_T
    );

    modport slave (
        output bist_start, Q_T,
        input  bist_busy, bist_done, bist_fail, fail_addr,
        input  BIST, CSN_T, WEN_T, A_T, D_T
    );
endinterface
`default_nettype wire

// File: rtl/register_file_1r_1w_bist_ctrl_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : register_file_bist_addr_gen
// Description : Up/down address counter with element-boundary load and a
//               last-address flag for the current direction.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_bist_addr_gen #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WORDS  = 2**ADDR_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  load_i,
    input  wire logic                  load_up_i,
    input  wire logic                  en_i,
    input  wire logic                  up_i,
    output logic      [ADDR_WIDTH-1:0] addr_o,
    output logic                       last_o
);
    localparam logic [ADDR_WIDTH-1:0] C_TOP = ADDR_WIDTH'(NUM_WORDS - 1);

    logic [ADDR_WIDTH-1:0] addr_q;

    // Load the element start address, or step one word in the element direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (load_i) begin
            addr_q <= load_up_i ? '0 : C_TOP;
        end else if (en_i) begin
            addr_q <= up_i ? addr_q + 1'b1 : addr_q - 1'b1;
        end
    end

    assign addr_o = addr_q;
    assign last_o = up_i ? (addr_q == C_TOP) : (addr_q == '0);

endmodule
`default_nettype wire

// File: rtl/register_file_1r_1w_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : register_file_1r_1w_bist_ctrl
// Description : March C- BIST sequencer for a 1r1w latch register file test
//               wrapper. One op per cycle, 1-cycle read latency compare,
//               sticky pass/fail with first failing address.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_1r_1w_bist_ctrl
    import register_file_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 2**ADDR_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    register_file_1r_1w_bist_ctrl_if.master bus
);
    bist_state_e           state_q, state_d;
    march_elem_e           elem_q, elem_d;
    logic                  op_q, op_d;          // 0 = first op of the address
    logic                  issued_q, issued_d;  // last E5 read has been issued
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic                  bist_q, bist_d;
    logic                  csn_q, csn_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  exp_q, exp_d;        // background of the read on the port
    logic                  cmp_vld_q;
    logic                  cmp_exp_q;
    logic [ADDR_WIDTH-1:0] cmp_addr_q;

    logic                  ag_load, ag_load_up, ag_en, ag_up, ag_last;
    logic [ADDR_WIDTH-1:0] ag_addr;
    logic                  is_rd;
    logic                  miss;

    assign ag_up = elem_up(elem_q);
    assign is_rd = (elem_q != E0) && !op_q;
    assign miss  = cmp_vld_q && (bus.Q_T != {DATA_WIDTH{cmp_exp_q}});

    register_file_bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WORDS  (NUM_WORDS)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (ag_load),
        .load_up_i (ag_load_up),
        .en_i      (ag_en),
        .up_i      (ag_up),
        .addr_o    (ag_addr),
        .last_o    (ag_last)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, op sequencing, port drive and result capture.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        op_d        = op_q;
        issued_d    = issued_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        bist_d      = bist_q;
        csn_d       = csn_q;
        wen_d       = wen_q;
        a_d         = a_q;
        d_d         = d_q;
        exp_d       = exp_q;
        ag_load     = 1'b0;
        ag_load_up  = 1'b1;
        ag_en       = 1'b0;

        // Only the first miscompare records its address.
        if (miss) begin
            fail_d = 1'b1;
            if (!fail_q) fail_addr_d = cmp_addr_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.bist_start) begin
                    state_d     = S_RUN;
                    busy_d      = 1'b1;
                    bist_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    elem_d      = E0;
                    op_d        = 1'b0;
                    issued_d    = 1'b0;
                    ag_load     = 1'b1;
                    ag_load_up  = 1'b1;
                end
            end
            S_RUN: begin
                if (issued_q) begin
                    state_d = S_DRAIN;
                    csn_d   = 1'b1;
                    wen_d   = 1'b1;
                end else begin
                    csn_d = 1'b0;
                    wen_d = is_rd;
                    a_d   = ag_addr;
                    if (is_rd) exp_d = elem_rd_bg(elem_q);
                    else       d_d   = {DATA_WIDTH{elem_wr_bg(elem_q)}};
                    // Step op, then address, then element.
                    if (elem_two(elem_q) && !op_q) begin
                        op_d = 1'b1;
                    end else begin
                        op_d = 1'b0;
                        if (!ag_last) begin
                            ag_en = 1'b1;
                        end else if (elem_q == E5) begin
                            issued_d = 1'b1;
                        end else begin
                            elem_d     = march_elem_e'(elem_q + 3'd1);
                            ag_load    = 1'b1;
                            ag_load_up = elem_up(march_elem_e'(elem_q + 3'd1));
                        end
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                bist_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers and the one-stage read compare pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_q      <= E0;
            op_q        <= 1'b0;
            issued_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            bist_q      <= 1'b0;
            csn_q       <= 1'b1;
            wen_q       <= 1'b1;
            a_q         <= '0;
            d_q         <= '0;
            exp_q       <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= 1'b0;
            cmp_addr_q  <= '0;
        end else begin
            elem_q      <= elem_d;
            op_q        <= op_d;
            issued_q    <= issued_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            bist_q      <= bist_d;
            csn_q       <= csn_d;
            wen_q       <= wen_d;
            a_q         <= a_d;
            d_q         <= d_d;
            exp_q       <= exp_d;
            cmp_vld_q   <= !csn_q && wen_q;
            cmp_exp_q   <= exp_q;
            cmp_addr_q  <= a_q;
        end
    end

    assign bus.bist_busy = busy_q;
    assign bus.bist_done = done_q;
    assign bus.bist_fail = fail_q;
    assign bus.fail_addr = fail_addr_q;
    assign bus.BIST      = bist_q;
    assign bus.CSN_T     = csn_q;
    assign bus.WEN_T     = wen_q;
    assign bus.A_T       = a_q;
    assign bus.D_T       = d_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file_1r_1w_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_1r_1w_bist_ctrl
// Description : Directed bench for the March C- BIST sequencer with an
//               8x8 register file model (1-cycle read latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_1r_1w_bist_ctrl;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int NW = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    register_file_1r_1w_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    register_file_1r_1w_bist_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file + wrapper model; fault_en makes bit 3 of address 5 read 0.
    logic [DW-1:0] mem [NW];
    logic [DW-1:0] q;
    logic          fault_en;
    assign bus.Q_T = q;

    always @(posedge clk) begin
        if (!bus.CSN_T) begin
            if (!bus.WEN_T) mem[bus.A_T] <= bus.D_T;
            else if (fault_en && bus.A_T == 3'd5) q <= mem[bus.A_T] & 8'hF7;
            else q <= mem[bus.A_T];
        end
    end

    // Trace of every selected cycle.
    logic          log_en;
    int            log_cnt;
    logic          log_wen [128];
    logic [AW-1:0] log_a   [128];
    logic [DW-1:0] log_d   [128];

    always @(posedge clk) begin
        if (log_en && !bus.CSN_T) begin
            if (log_cnt < 128) begin
                log_wen[log_cnt] <= bus.WEN_T;
                log_a[log_cnt]   <= bus.A_T;
                log_d[log_cnt]   <= bus.D_T;
            end
            log_cnt <= log_cnt + 1;
        end
    end

    task automatic pulse_start();
        @(negedge clk) bus.bist_start = 1'b1;
        @(negedge clk) bus.bist_start = 1'b0;
    endtask

    // Count cycles until done; optionally raise start for a window of cycles.
    task automatic run_until_done(input int on_cyc, input int off_cyc, output int cyc);
        cyc = 0;
        while (!bus.bist_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == on_cyc)  bus.bist_start = 1'b1;
            if (cyc == off_cyc) bus.bist_start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.bist_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.bist_busy); end
        checks++; if (bus.bist_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.bist_done); end
        checks++; if (bus.bist_fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b exp 0", bus.bist_fail); end
        checks++; if (bus.fail_addr !== 3'd0) begin errors++; $display("FAIL reset_fail_addr got %0d exp 0", bus.fail_addr); end
        checks++; if (bus.BIST !== 1'b0) begin errors++; $display("FAIL reset_BIST got %b exp 0", bus.BIST); end
        checks++; if (bus.CSN_T !== 1'b1) begin errors++; $display("FAIL reset_CSN_T got %b exp 1", bus.CSN_T); end
        checks++; if (bus.WEN_T !== 1'b1) begin errors++; $display("FAIL reset_WEN_T got %b exp 1", bus.WEN_T); end
        checks++; if (bus.A_T !== 3'd0) begin errors++; $display("FAIL reset_A_T got %0d exp 0", bus.A_T); end
        checks++; if (bus.D_T !== 8'h00) begin errors++; $display("FAIL reset_D_T got %h exp 00", bus.D_T); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fault_free_trace();
        int            cyc;
        logic          ew [80];
        logic [AW-1:0] ea [80];
        logic [DW-1:0] ed [80];
        int            n;
        n = 0;
        for (int a = 0; a < 8; a++) begin ew[n] = 0; ea[n] = a; ed[n] = 8'h00; n++; end
        for (int a = 0; a < 8; a++) begin
            ew[n] = 1; ea[n] = a; ed[n] = 8'h00; n++; ew[n] = 0; ea[n] = a; ed[n] = 8'hFF; n++;
        end
        for (int a = 0; a < 8; a++) begin
            ew[n] = 1; ea[n] = a; ed[n] = 8'h00; n++; ew[n] = 0; ea[n] = a; ed[n] = 8'h00; n++;
        end
        for (int a = 7; a >= 0; a--) begin
            ew[n] = 1; ea[n] = a; ed[n] = 8'h00; n++; ew[n] = 0; ea[n] = a; ed[n] = 8'hFF; n++;
        end
        for (int a = 7; a >= 0; a--) begin
            ew[n] = 1; ea[n] = a; ed[n] = 8'h00; n++; ew[n] = 0; ea[n] = a; ed[n] = 8'h00; n++;
        end
        for (int a = 0; a < 8; a++) begin ew[n] = 1; ea[n] = a; ed[n] = 8'h00; n++; end

        @(negedge clk);
        log_cnt = 0;
        log_en  = 1'b1;
        pulse_start();
        checks++; if (bus.bist_busy !== 1'b1) begin errors++; $display("FAIL ff_busy_after_start got %b exp 1", bus.bist_busy); end
        checks++; if (bus.BIST !== 1'b1) begin errors++; $display("FAIL ff_BIST_after_start got %b exp 1", bus.BIST); end
        run_until_done(-1, -1, cyc);
        checks++; if (cyc !== 82) begin errors++; $display("FAIL ff_latency got %0d exp 82", cyc); end
        checks++; if (bus.bist_fail !== 1'b0) begin errors++; $display("FAIL ff_fail got %b exp 0", bus.bist_fail); end
        checks++; if (bus.fail_addr !== 3'd0) begin errors++; $display("FAIL ff_fail_addr got %0d exp 0", bus.fail_addr); end
        checks++; if (bus.bist_busy !== 1'b0) begin errors++; $display("FAIL ff_busy_at_done got %b exp 0", bus.bist_busy); end
        checks++; if (bus.BIST !== 1'b0) begin errors++; $display("FAIL ff_BIST_at_done got %b exp 0", bus.BIST); end
        checks++; if (bus.CSN_T !== 1'b1) begin errors++; $display("FAIL ff_CSN_T_idle got %b exp 1", bus.CSN_T); end
        checks++; if (bus.A_T !== 3'd7) begin errors++; $display("FAIL ff_A_T_hold got %0d exp 7", bus.A_T); end
        log_en = 1'b0;
        checks++; if (log_cnt !== 80) begin errors++; $display("FAIL trace_count got %0d exp 80", log_cnt); end
        for (int i = 0; i < 80; i++) begin
            checks++;
            if (log_wen[i] !== ew[i] || log_a[i] !== ea[i] || (!ew[i] && log_d[i] !== ed[i])) begin
                errors++;
                $display("FAIL trace_op[%0d] got wen=%b a=%0d d=%h exp wen=%b a=%0d d=%h",
                         i, log_wen[i], log_a[i], log_d[i], ew[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_stuck_at();
        int cyc;
        fault_en = 1'b1;
        pulse_start();
        run_until_done(-1, -1, cyc);
        checks++; if (cyc !== 82) begin errors++; $display("FAIL sa_latency got %0d exp 82", cyc); end
        checks++; if (bus.bist_fail !== 1'b1) begin errors++; $display("FAIL sa_fail got %b exp 1", bus.bist_fail); end
        checks++; if (bus.fail_addr !== 3'd5) begin errors++; $display("FAIL sa_fail_addr got %0d exp 5", bus.fail_addr); end
        fault_en = 1'b0;
    endtask

    task automatic test_restart();
        int cyc;
        pulse_start();
        checks++; if (bus.bist_done !== 1'b0) begin errors++; $display("FAIL rs_done_cleared got %b exp 0", bus.bist_done); end
        checks++; if (bus.bist_fail !== 1'b0) begin errors++; $display("FAIL rs_fail_cleared got %b exp 0", bus.bist_fail); end
        checks++; if (bus.fail_addr !== 3'd0) begin errors++; $display("FAIL rs_fail_addr_cleared got %0d exp 0", bus.fail_addr); end
        run_until_done(-1, -1, cyc);
        checks++; if (cyc !== 82) begin errors++; $display("FAIL rs_latency got %0d exp 82", cyc); end
        checks++; if (bus.bist_fail !== 1'b0) begin errors++; $display("FAIL rs_fail got %b exp 0", bus.bist_fail); end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        pulse_start();
        run_until_done(20, 21, cyc);
        checks++; if (cyc !== 82) begin errors++; $display("FAIL busy_start_latency got %0d exp 82", cyc); end
        checks++; if (bus.bist_fail !== 1'b0) begin errors++; $display("FAIL busy_start_fail got %b exp 0", bus.bist_fail); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        // Start seen only on the DRAIN->DONE edge: lost.
        pulse_start();
        run_until_done(81, 82, cyc);
        checks++; if (cyc !== 82) begin errors++; $display("FAIL lost_latency got %0d exp 82", cyc); end
        repeat (3) @(negedge clk);
        checks++; if (bus.bist_done !== 1'b1) begin errors++; $display("FAIL lost_done_kept got %b exp 1", bus.bist_done); end
        checks++; if (bus.bist_busy !== 1'b0) begin errors++; $display("FAIL lost_busy got %b exp 0", bus.bist_busy); end
        // Start held across the DONE transition: accepted one cycle later.
        pulse_start();
        run_until_done(81, -1, cyc);
        checks++; if (cyc !== 82) begin errors++; $display("FAIL held_first_latency got %0d exp 82", cyc); end
        @(negedge clk);
        bus.bist_start = 1'b0;
        checks++; if (bus.bist_done !== 1'b0) begin errors++; $display("FAIL held_done_cleared got %b exp 0", bus.bist_done); end
        checks++; if (bus.bist_busy !== 1'b1) begin errors++; $display("FAIL held_busy got %b exp 1", bus.bist_busy); end
        run_until_done(-1, -1, cyc);
        checks++; if (cyc !== 82) begin errors++; $display("FAIL held_second_latency got %0d exp 82", cyc); end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        repeat (40) @(negedge clk);
        checks++; if (bus.CSN_T !== 1'b0) begin errors++; $display("FAIL mid_CSN_T_active got %b exp 0", bus.CSN_T); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.BIST !== 1'b0) begin errors++; $display("FAIL mid_BIST got %b exp 0", bus.BIST); end
        checks++; if (bus.CSN_T !== 1'b1) begin errors++; $display("FAIL mid_CSN_T got %b exp 1", bus.CSN_T); end
        checks++; if (bus.bist_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", bus.bist_busy); end
        checks++; if (bus.bist_done !== 1'b0) begin errors++; $display("FAIL mid_done got %b exp 0", bus.bist_done); end
        checks++; if (bus.bist_fail !== 1'b0) begin errors++; $display("FAIL mid_fail got %b exp 0", bus.bist_fail); end
        checks++; if (bus.fail_addr !== 3'd0) begin errors++; $display("FAIL mid_fail_addr got %0d exp 0", bus.fail_addr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.bist_busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %b exp 0", bus.bist_busy); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.bist_start = 1'b0;
        fault_en       = 1'b0;
        log_en         = 1'b0;
        log_cnt        = 0;
        q              = '0;
        test_reset();
        test_fault_free_trace();
        test_stuck_at();
        test_restart();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
